// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA pattern sequencer slice.
package vga_pkg;
  localparam int RGB_W   = 10;
  localparam int COORD_W = 10;
  localparam int PIX_W   = 3 * RGB_W;
  localparam int MAX_PAT = 8;

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} seq_state_t;

  // Pick pattern k's {R,G,B} word out of a bus padded to MAX_PAT sources.
  function automatic logic [PIX_W-1:0] rgb_slice(input logic [MAX_PAT*PIX_W-1:0] bus,
                                                 input logic [2:0] k);
    return bus[k*PIX_W +: PIX_W];
  endfunction
endpackage

// File: rtl/vga_key_sync.sv
// Multi-flop synchronizer; EDGE=1 turns the output into a falling-edge pulse.
module vga_key_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGE    = 1'b0
) (
  input  logic iVGA_CLK,
  input  logic iRST_N,
  input  logic din,
  output logic dout
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N)
    if (!iRST_N) sync_q <= {STAGES{RST_VAL}};
    else         sync_q <= sync_d;

  generate
    if (EDGE) begin : g_edge
      logic prev_q, prev_d;
      always_comb prev_d = sync_q[STAGES-1];
      always_ff @(posedge iVGA_CLK or negedge iRST_N)
        if (!iRST_N) prev_q <= RST_VAL;
        else         prev_q <= prev_d;
      assign dout = prev_q & ~sync_q[STAGES-1];
    end else begin : g_lvl
      assign dout = sync_q[STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-aligned test-pattern selector with black-frame insertion between patterns.
// Optional fade-in after each switch is enabled by defining VGA_SEQ_FADE_EN.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int N_PAT        = 4,
  parameter int AUTO_FRAMES  = 300,
  parameter int BLANK_FRAMES = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                     iVGA_CLK,
  input  logic                     iRST_N,
  input  logic [COORD_W-1:0]       iVGA_X,
  input  logic [COORD_W-1:0]       iVGA_Y,
  input  logic [N_PAT*PIX_W-1:0]   iPAT_RGB,
  input  logic                     iKEY_N,
  input  logic                     iAUTO,
  output logic [RGB_W-1:0]         oRed,
  output logic [RGB_W-1:0]         oGreen,
  output logic [RGB_W-1:0]         oBlue,
  output logic [$clog2(N_PAT)-1:0] oPAT_SEL,
  output logic                     oBLANKING
);
  localparam int SEL_W = $clog2(N_PAT);
  localparam int DW    = $clog2(AUTO_FRAMES + 1);
  localparam int BW    = $clog2(BLANK_FRAMES + 1);

  logic key_press, auto_lvl;

  vga_key_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE(1'b1)) u_key (
    .iVGA_CLK(iVGA_CLK), .iRST_N(iRST_N), .din(iKEY_N), .dout(key_press));
  vga_key_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE(1'b0)) u_auto (
    .iVGA_CLK(iVGA_CLK), .iRST_N(iRST_N), .din(iAUTO), .dout(auto_lvl));

  seq_state_t             state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d, next_sel_q, next_sel_d;
  logic [BW-1:0]          blank_cnt_q, blank_cnt_d;
  logic [DW-1:0]          dwell_q, dwell_d;
  logic                   pending_q, pending_d;
  logic                   origin_q, origin_d;
  logic [PIX_W-1:0]       rgb_q, rgb_d;
  logic                   fs, take, auto_req;
  logic [MAX_PAT*PIX_W-1:0] pat_bus;
  logic [PIX_W-1:0]       src;
`ifdef VGA_SEQ_FADE_EN
  logic [1:0]             fade_q, fade_d;
`endif

  always_comb begin
    origin_d    = (iVGA_X == '0) && (iVGA_Y == '0);
    fs          = origin_d & ~origin_q;
    state_d     = state_q;
    sel_d       = sel_q;
    next_sel_d  = next_sel_q;
    blank_cnt_d = blank_cnt_q;
    dwell_d     = dwell_q;
    take        = 1'b0;
    auto_req    = 1'b0;
`ifdef VGA_SEQ_FADE_EN
    fade_d      = fade_q;
`endif
    case (state_q)
      SHOW: begin
        if (!auto_lvl) dwell_d = '0;
        else if (fs) begin
          if (dwell_q == DW'(AUTO_FRAMES - 1)) auto_req = 1'b1;
          else                                 dwell_d  = dwell_q + 1'b1;
        end
`ifdef VGA_SEQ_FADE_EN
        if (fs && fade_q != 2'd0) fade_d = fade_q - 2'd1;
`endif
        // Manual and auto requests at the same fs collapse into one advance.
        if (fs && (pending_q || auto_req)) begin
          take        = 1'b1;
          state_d     = BLANK;
          blank_cnt_d = BW'(BLANK_FRAMES - 1);
          next_sel_d  = (sel_q == SEL_W'(N_PAT - 1)) ? '0 : sel_q + 1'b1;
          dwell_d     = '0;
        end
      end
      BLANK: begin
        dwell_d = '0;
        if (fs) begin
          if (blank_cnt_q == '0) begin
            state_d = SHOW;
            sel_d   = next_sel_q;
`ifdef VGA_SEQ_FADE_EN
            fade_d  = 2'd3;
`endif
          end else begin
            blank_cnt_d = blank_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = SHOW;
    endcase
    pending_d = (pending_q & ~take) | key_press;

    // Output is driven from next-state so data and oPAT_SEL move on the same edge.
    pat_bus                    = '0;
    pat_bus[N_PAT*PIX_W-1:0]   = iPAT_RGB;
    src                        = rgb_slice(pat_bus, 3'(sel_d));
`ifdef VGA_SEQ_FADE_EN
    src = {src[3*RGB_W-1:2*RGB_W] >> fade_d, src[2*RGB_W-1:RGB_W] >> fade_d,
           src[RGB_W-1:0] >> fade_d};
`endif
    rgb_d = (state_d == SHOW) ? src : '0;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_N)
    if (!iRST_N) begin
      state_q     <= SHOW;
      sel_q       <= '0;
      next_sel_q  <= '0;
      blank_cnt_q <= '0;
      dwell_q     <= '0;
      pending_q   <= 1'b0;
      origin_q    <= 1'b0;
      rgb_q       <= '0;
`ifdef VGA_SEQ_FADE_EN
      fade_q      <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      next_sel_q  <= next_sel_d;
      blank_cnt_q <= blank_cnt_d;
      dwell_q     <= dwell_d;
      pending_q   <= pending_d;
      origin_q    <= origin_d;
      rgb_q       <= rgb_d;
`ifdef VGA_SEQ_FADE_EN
      fade_q      <= fade_d;
`endif
    end

  assign oRed      = rgb_q[3*RGB_W-1:2*RGB_W];
  assign oGreen    = rgb_q[2*RGB_W-1:RGB_W];
  assign oBlue     = rgb_q[RGB_W-1:0];
  assign oPAT_SEL  = sel_q;
  assign oBLANKING = (state_q == BLANK);
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Frame-level scoreboard bench: expectations queued per frame, checked mid-frame by a monitor.
module tb_vga_pattern_sequencer;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    x, y;
  logic [NP*30-1:0] pat;
  logic          key_n, auto_en;
  logic [9:0]    r, g, b;
  logic [1:0]    sel;
  logic          blk;

  vga_pattern_sequencer #(.N_PAT(NP), .AUTO_FRAMES(3), .BLANK_FRAMES(1), .SYNC_STAGES(2)) dut (
    .iVGA_CLK(clk), .iRST_N(rst_n), .iVGA_X(x), .iVGA_Y(y), .iPAT_RGB(pat),
    .iKEY_N(key_n), .iAUTO(auto_en), .oRed(r), .oGreen(g), .oBlue(b),
    .oPAT_SEL(sel), .oBLANKING(blk));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        blk;
    logic [29:0] rgb;
    int          id;
  } exp_t;

  exp_t q[$];
  event smp_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [29:0] src_rgb(input int k);
    return {10'(k * 100), 10'd0, 10'd512};
  endfunction

  task automatic push_exp(input int id, input int s, input bit bl, input logic [29:0] rgb);
    exp_t e;
    e.id = id; e.sel = 2'(s); e.blk = bl; e.rgb = rgb;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per sample point.
  initial forever begin
    exp_t e;
    @(smp_ev);
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL underflow: sample with no expectation queued");
    end else begin
      e = q.pop_front();
      if (sel !== e.sel || blk !== e.blk || {r, g, b} !== e.rgb) begin
        n_bad++;
        $display("FAIL chk%0d: got sel=%0d blk=%0b rgb=(%0d,%0d,%0d) want sel=%0d blk=%0b rgb=(%0d,%0d,%0d)",
                 e.id, sel, blk, r, g, b, e.sel, e.blk, e.rgb[29:20], e.rgb[19:10], e.rgb[9:0]);
      end
    end
  end

  // One 10x5 frame; presses start at pixel 30, spaced 6 pixels; sample at pixel 25.
  task automatic frame(input int presses, input int au, input int hold0, input int npix);
    for (int p = 0; p < npix; p++) begin
      bit kl;
      @(negedge clk);
      x = 10'(p % 10);
      y = 10'(p / 10);
      kl = 1'b0;
      for (int j = 0; j < presses; j++)
        if (p == 30 + 6*j || p == 31 + 6*j) kl = 1'b1;
      key_n = ~kl;
      if (p == 30 && au >= 0) auto_en = au[0];
      if (p == 0) repeat (hold0) @(negedge clk);
      if (p == 25) begin
        @(posedge clk);
        #1 -> smp_ev;
      end
    end
  endtask

  // Per-frame script: presses, auto change (-1 none), expected sel, expected blanking.
  int t_pr[30] = '{0,0,0,0,1, 0,0,3,0,1, 0,1,0,1,1, 0,0,0,0,0, 0,0,0,1,0, 0,0,0,0,1};
  int t_au[30] = '{-1,-1,-1,-1,-1, -1,-1,-1,-1,-1, -1,-1,-1,-1,-1,
                   -1,-1,1,-1,-1, -1,-1,-1,-1,-1, -1,-1,0,-1,-1};
  int t_s[30]  = '{0,0,0,0,0, 0,1,1,1,2, 2,3,3,0,0, 1,1,2,2,2, 2,3,3,3,3, 0,0,0,0,0};
  int t_b[30]  = '{0,0,0,0,0, 1,0,0,1,0, 1,0,1,0,1, 0,1,0,0,0, 1,0,0,0,1, 0,0,0,0,0};

  initial begin
    rst_n = 1'b0; x = 10'd1; y = 10'd0; key_n = 1'b1; auto_en = 1'b0;
    for (int k = 0; k < NP; k++) pat[k*30 +: 30] = src_rgb(k);

    repeat (3) @(posedge clk);
    push_exp(100, 0, 1'b0, 30'd0);
    #1 -> smp_ev;
    @(negedge clk) rst_n = 1'b1;
    push_exp(101, 0, 1'b0, src_rgb(0));
    repeat (2) @(posedge clk);
    #1 -> smp_ev;

    for (int f = 0; f < 30; f++) begin
      push_exp(f, t_s[f], t_b[f][0], t_b[f] != 0 ? 30'd0 : src_rgb(t_s[f]));
      frame(t_pr[f], t_au[f], (f == 5) ? 20 : 0, 50);
    end

    // Blank frame with a press pending, then reset asserted mid-blank.
    push_exp(30, 0, 1'b1, 30'd0);
    frame(1, -1, 0, 45);
    #2;
    push_exp(102, 0, 1'b0, 30'd0);
    rst_n = 1'b0; x = 10'd1; y = 10'd0;
    #1 -> smp_ev;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    push_exp(103, 0, 1'b0, src_rgb(0));
    repeat (2) @(posedge clk);
    #1 -> smp_ev;
    for (int f = 31; f < 34; f++) begin
      push_exp(f, 0, 1'b0, src_rgb(0));
      frame(0, -1, 0, 50);
    end

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: %0d expectations never sampled, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
Selects one of N_PAT test-pattern generators and drives the VGA RGB outputs from it. Pattern changes are requested by a pushbutton or an auto-advance timer, and take effect only on frame boundaries. One or more black frames are inserted between patterns. The block sits between the pattern generator bank and the VGA controller's RGB inputs.

Parameters:
N_PAT, 4, number of pattern sources (2..8)
AUTO_FRAMES, 300, frames shown per pattern in auto mode (≥1)
BLANK_FRAMES, 1, black frames inserted on each switch (≥1)
SYNC_STAGES, 2, synchronizer depth for iKEY_N and iAUTO

Ports:
iVGA_CLK  in  1  pixel clock
iRST_N  in  1  async reset, active-low
iVGA_X  in  10  current pixel X from VGA controller
iVGA_Y  in  10  current pixel Y from VGA controller
iPAT_RGB  in  N_PAT*30  packed sources; slice k = {R[9:0],G[9:0],B[9:0]} of pattern k
iKEY_N  in  1  async pushbutton, active-low, "next pattern"
iAUTO  in  1  async level, 1 = auto-advance enabled
oRed  out  10  selected red
oGreen  out  10  selected green
oBlue  out  10  selected blue
oPAT_SEL  out  $clog2(N_PAT)  index currently displayed
oBLANKING  out  1  high while black frames are inserted

Behaviour:
- Reset: iRST_N (asynchronous, active-low) with clock iVGA_CLK. Asserting reset, including mid-frame or mid-blank, immediately forces:
  - oRed/oGreen/oBlue = 0, oPAT_SEL = 0, oBLANKING = 0
  - state = SHOW, dwell counter = 0, pending = 0, synchronizers cleared (key treated as released)
- Inputs: iKEY_N and iAUTO pass through SYNC_STAGES flops. A key press is the falling edge of the synced iKEY_N and produces a 1-cycle press pulse. No debounce.
- Frame start (fs): 1-cycle pulse on the cycle where (iVGA_X==0 && iVGA_Y==0) is true and was false the previous cycle. X/Y held at 0 for many cycles still yields one fs.
- Pending flag: set by a press pulse. Cleared when a switch is taken. Multiple presses before the next fs still cause one advance.
- Dwell counter: counts fs in SHOW while synced iAUTO==1. Reaching AUTO_FRAMES-1 at an fs requests a switch. The counter resets to 0 on any switch or when iAUTO==0.
- State SHOW:
  - Output = slice oPAT_SEL of iPAT_RGB.
  - At fs with (pending | auto request): go to BLANK, load blank counter = BLANK_FRAMES-1, next_sel = (oPAT_SEL==N_PAT-1) ? 0 : oPAT_SEL+1, clear pending.
  - Press and auto request at the same fs: single advance.
- State BLANK:
  - Output 0/0/0, oBLANKING = 1.
  - At each fs: if blank counter==0, go to SHOW with oPAT_SEL = next_sel; otherwise decrement.
  - Presses in BLANK set pending, which is serviced at the first fs in SHOW (after a full dwell-independent frame). The switch is taken at the following fs, so a new pattern always gets at least one full frame.
- Output timing: RGB, oPAT_SEL and oBLANKING are registered with 1 iVGA_CLK latency from iPAT_RGB and from the state change. oPAT_SEL updates on the same edge the new pattern data appears.
- Widths: all RGB paths are 10 bits, unsigned, with no arithmetic except the optional fade.

Optional Feature:
- VGA_SEQ_FADE_EN
  - Defined: after BLANK→SHOW, output = source >> fade_sh for 4 frames, with fade_sh = 3,2,1,0 (decrementing at each fs), then unshifted. A switch request during the fade is still honoured at fs.
  - Undefined: no fade logic; the new pattern is shown at full intensity from its first frame.

Decomposition:
- Shared package vga_pkg:
  - localparam RGB_W = 10
  - COORD_W = 10
  - enum seq_state_t {SHOW, BLANK}
  - function for slicing a packed RGB word
- Sub-module vga_key_sync: synchronizer plus falling-edge pulse, instantiated twice: once for iKEY_N (with edge detect), once for iAUTO (level only).

Test Plan:
- Reset, then N_PAT=4 with sources k = RGB(k*100, 0, 512) and iAUTO=0: oPAT_SEL=0, output (0,0,512) after 1 clk. No change over 5 frames.
- Press key mid-frame 0 → next fs: oBLANKING=1, RGB=0 for exactly 1 frame. Following fs: oPAT_SEL=1, RGB=(100,0,512).
- With oPAT_SEL=3, press → after blank, oPAT_SEL=0 (wrap).
- AUTO_FRAMES=3, iAUTO=1 → switch every 3 shown frames + 1 blank. Press and auto at the same fs → single advance only.
- Three presses within one frame → single advance. Press during BLANK → serviced one frame after entering SHOW.
- Assert iRST_N=0 during BLANK → RGB=0, oPAT_SEL=0, oBLANKING=0 immediately. After release, SHOW pattern 0 with no pending switch.
